vec_splat_writer: RTL and testbench

Scalar-to-vector broadcast writer for the vector ALU: accepts one scalar operand with SEW and vector length, replicates it across every element, and streams it as full-width register-file write beats with address and byte enables. It is the scalar→vector counterpart of the reduction path. The reduction path collapses vector beats into a single byte-enabled scalar write; this block expands a scalar into a byte-enabled beat stream that feeds the same VRF write port.

---
 rtl/vsplat_pkg.sv | 58 +++++
 rtl/vsplat_be_gen.sv | 34 +++
 rtl/vec_splat_writer.sv | 145 ++++++++++++++
 tb/tb_vec_splat_writer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vsplat_pkg.sv
// -----------------------------------------------------------------------------
// vsplat_pkg
// Shared types and helpers for the scalar-to-vector splat writer.
//   - state_e      : writer FSM states (IDLE, RUN)
//   - SEW_*        : element-width encodings (00=8, 01=16, 10=32, 11=64)
//   - epb()        : elements per beat for a given SEW
//   - sew_legal()  : whether an SEW encoding is accepted by this build
//   - replicate()  : broadcast the low SEW bits of a scalar across a beat
// Optional feature macro: RVV_SPLAT_SEW64_EN enables SEW=64 support.
// -----------------------------------------------------------------------------
package vsplat_pkg;

   localparam int REQ_DATA_WIDTH = 64;
   localparam int REQ_BE_WIDTH   = REQ_DATA_WIDTH / 8;
   localparam int REQ_ADDR_WIDTH = 32;
   localparam int SEW_WIDTH      = 2;
   localparam int VL_WIDTH       = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic [SEW_WIDTH-1:0] SEW_8  = 2'b00;
   localparam logic [SEW_WIDTH-1:0] SEW_16 = 2'b01;
   localparam logic [SEW_WIDTH-1:0] SEW_32 = 2'b10;
   localparam logic [SEW_WIDTH-1:0] SEW_64 = 2'b11;

   // Elements per beat: 8 / 4 / 2 / 1 for SEW 8 / 16 / 32 / 64.
   function automatic logic [VL_WIDTH-1:0] epb(input logic [SEW_WIDTH-1:0] sew);
      return VL_WIDTH'(REQ_BE_WIDTH) >> sew;
   endfunction

   function automatic logic sew_legal(input logic [SEW_WIDTH-1:0] sew);
`ifdef RVV_SPLAT_SEW64_EN
      return 1'b1;
`else
      return (sew != SEW_64);
`endif
   endfunction

   function automatic logic [REQ_DATA_WIDTH-1:0] replicate(input logic [63:0]          scalar,
                                                           input logic [SEW_WIDTH-1:0] sew);
      logic [REQ_DATA_WIDTH-1:0] r;
      r = '0;
      case (sew)
         SEW_8:  r = {(REQ_DATA_WIDTH/8){scalar[7:0]}};
         SEW_16: r = {(REQ_DATA_WIDTH/16){scalar[15:0]}};
         SEW_32: r = {(REQ_DATA_WIDTH/32){scalar[31:0]}};
`ifdef RVV_SPLAT_SEW64_EN
         SEW_64: r = {(REQ_DATA_WIDTH/64){scalar}};
`endif
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/vsplat_be_gen.sv
// -----------------------------------------------------------------------------
// vsplat_be_gen
// Combinational byte-enable generator for one splat beat.
//   rem_i  : elements still to write, including this beat
//   sew_i  : element width encoding
//   last_i : this is the final beat of the command
//   be_o   : all ones for non-final beats; otherwise the low (rem << sew) bits
// -----------------------------------------------------------------------------
module vsplat_be_gen
   import vsplat_pkg::*;
#(
   parameter int VL_W = VL_WIDTH,
   parameter int BE_W = REQ_BE_WIDTH
) (
   input  logic [VL_W-1:0]      rem_i,
   input  logic [SEW_WIDTH-1:0] sew_i,
   input  logic                 last_i,
   output logic [BE_W-1:0]      be_o
);

   logic [VL_W-1:0] live_bytes;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; a missing default is how latches get inferred.
   always_comb begin
      live_bytes = rem_i << sew_i;
      be_o       = '0;
      for (int i = 0; i < BE_W; i++) begin
         // On the last beat rem <= EPB, so live_bytes never exceeds BE_W.
         be_o[i] = !last_i || (VL_W'(i) < live_bytes);
      end
   end

endmodule

// File: rtl/vec_splat_writer.sv
// -----------------------------------------------------------------------------
// vec_splat_writer
// Scalar-to-vector broadcast writer: accepts one scalar with SEW and vector
// length, replicates it across the beat and streams byte-enabled VRF write
// beats with consecutive word addresses.
// Ports:
//   clk, rst                     : clock, asynchronous active-low reset
//   in_valid/in_ready            : command handshake
//   in_scalar/in_sew/in_vl/in_addr : command payload
//   out_valid/out_ready          : beat handshake
//   out_vec/out_addr/out_be/out_last : registered beat payload
//   out_err                      : one-cycle pulse, illegal-SEW command dropped
// Optional feature macro: RVV_SPLAT_SEW64_EN (SEW=64 legal when defined).
// -----------------------------------------------------------------------------
module vec_splat_writer
   import vsplat_pkg::*;
#(
   parameter int REQ_DATA_WIDTH = vsplat_pkg::REQ_DATA_WIDTH,
   parameter int REQ_BE_WIDTH   = REQ_DATA_WIDTH / 8,
   parameter int REQ_ADDR_WIDTH = vsplat_pkg::REQ_ADDR_WIDTH,
   parameter int SEW_WIDTH      = vsplat_pkg::SEW_WIDTH,
   parameter int VL_WIDTH       = vsplat_pkg::VL_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [63:0]               in_scalar,
   input  logic [SEW_WIDTH-1:0]      in_sew,
   input  logic [VL_WIDTH-1:0]       in_vl,
   input  logic [REQ_ADDR_WIDTH-1:0] in_addr,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [REQ_DATA_WIDTH-1:0] out_vec,
   output logic [REQ_ADDR_WIDTH-1:0] out_addr,
   output logic [REQ_BE_WIDTH-1:0]   out_be,
   output logic                      out_last,
   output logic                      out_err
);

   state_e                    state_q;
   logic                      in_ready_q;
   logic [VL_WIDTH-1:0]       rem_q;
   logic [SEW_WIDTH-1:0]      sew_q;
   logic                      out_valid_q;
   logic [REQ_DATA_WIDTH-1:0] out_vec_q;
   logic [REQ_ADDR_WIDTH-1:0] out_addr_q;
   logic [REQ_BE_WIDTH-1:0]   out_be_q;
   logic                      out_last_q;
   logic                      out_err_q;

   // Next beat to present: the first beat of an incoming command while IDLE,
   // otherwise the beat that follows the one currently in the output register.
   logic [VL_WIDTH-1:0]       beat_rem_d;
   logic [SEW_WIDTH-1:0]      beat_sew_d;
   logic                      beat_last_d;
   logic [REQ_BE_WIDTH-1:0]   beat_be_d;

   always_comb begin
      beat_sew_d = sew_q;
      beat_rem_d = rem_q - epb(sew_q);
      if (state_q == IDLE) begin
         beat_sew_d = in_sew;
         beat_rem_d = in_vl;
      end
      beat_last_d = (beat_rem_d <= epb(beat_sew_d));
   end

   vsplat_be_gen #(
      .VL_W (VL_WIDTH),
      .BE_W (REQ_BE_WIDTH)
   ) u_be_gen (
      .rem_i  (beat_rem_d),
      .sew_i  (beat_sew_d),
      .last_i (beat_last_d),
      .be_o   (beat_be_d)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         rem_q       <= '0;
         sew_q       <= '0;
         out_valid_q <= 1'b0;
         out_vec_q   <= '0;
         out_addr_q  <= '0;
         out_be_q    <= '0;
         out_last_q  <= 1'b0;
         out_err_q   <= 1'b0;
      end else begin
         out_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (in_valid && in_ready_q) begin
                  if (!sew_legal(in_sew)) begin
                     out_err_q <= 1'b1;
                  end else if (in_vl != '0) begin
                     state_q     <= RUN;
                     in_ready_q  <= 1'b0;
                     sew_q       <= in_sew;
                     rem_q       <= in_vl;
                     out_valid_q <= 1'b1;
                     out_vec_q   <= replicate(in_scalar, in_sew);
                     out_addr_q  <= in_addr;
                     out_be_q    <= beat_be_d;
                     out_last_q  <= beat_last_d;
                  end
               end
            end
            RUN: begin
               // The output register only changes on a handshake, so a
               // stalled beat stays bit-stable.
               if (out_ready) begin
                  if (out_last_q) begin
                     state_q     <= IDLE;
                     in_ready_q  <= 1'b1;
                     out_valid_q <= 1'b0;
                     out_be_q    <= '0;
                     out_last_q  <= 1'b0;
                  end else begin
                     rem_q      <= beat_rem_d;
                     out_addr_q <= out_addr_q + REQ_ADDR_WIDTH'(1);
                     out_be_q   <= beat_be_d;
                     out_last_q <= beat_last_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_vec   = out_vec_q;
   assign out_addr  = out_addr_q;
   assign out_be    = out_be_q;
   assign out_last  = out_last_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_vec_splat_writer.sv
// -----------------------------------------------------------------------------
// tb_vec_splat_writer
// Directed bench for vec_splat_writer. Inputs change and outputs are sampled on
// the falling clock edge; the design acts on the rising edge.
// Honors RVV_SPLAT_SEW64_EN for the SEW=64 expectations.
// -----------------------------------------------------------------------------
module tb_vec_splat_writer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_scalar;
   logic [1:0]  in_sew;
   logic [15:0] in_vl;
   logic [31:0] in_addr;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_vec;
   logic [31:0] out_addr;
   logic [7:0]  out_be;
   logic        out_last;
   logic        out_err;

   int pass_cnt  = 0;
   int total_cnt = 0;

   vec_splat_writer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_scalar (in_scalar),
      .in_sew    (in_sew),
      .in_vl     (in_vl),
      .in_addr   (in_addr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vec   (out_vec),
      .out_addr  (out_addr),
      .out_be    (out_be),
      .out_last  (out_last),
      .out_err   (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Beat tuple {valid, vec, addr, be, last} = 1+64+32+8+1 = 106 bits.
   function automatic logic [105:0] beat_now();
      return {out_valid, out_vec, out_addr, out_be, out_last};
   endfunction

   // Called at a falling edge; issues one command, returns at the falling
   // edge after the accepting rising edge.
   task automatic send_cmd(input logic [1:0] sew, input logic [63:0] scalar,
                           input logic [15:0] vl, input logic [31:0] addr);
      int waited = 0;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL cmd_ready_timeout in_ready=%b required=1", in_ready);
      else pass_cnt++;
      in_valid  = 1'b1;
      in_sew    = sew;
      in_scalar = scalar;
      in_vl     = vl;
      in_addr   = addr;
      @(negedge clk);
      in_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      total_cnt++;
      if ({in_ready, out_valid, out_vec, out_addr, out_be, out_last, out_err} !== '0)
         $display("FAIL reset_outputs got rdy=%b v=%b vec=%h addr=%h be=%h last=%b err=%b required all zero",
                  in_ready, out_valid, out_vec, out_addr, out_be, out_last, out_err);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_release_ready got %b required 1", in_ready);
      else pass_cnt++;
   endtask

   task automatic test_sew8();
      logic [105:0] exp_b [2];
      exp_b[0] = {1'b1, 64'hA5A5A5A5A5A5A5A5, 32'h40, 8'hFF, 1'b0};
      exp_b[1] = {1'b1, 64'hA5A5A5A5A5A5A5A5, 32'h41, 8'h03, 1'b1};
      out_ready = 1'b1;
      send_cmd(2'b00, 64'h00000000000000A5, 16'd10, 32'h40);
      for (int i = 0; i < 2; i++) begin
         total_cnt++;
         if (beat_now() !== exp_b[i]) $display("FAIL sew8_beat%0d got %h required %h", i, beat_now(), exp_b[i]);
         else pass_cnt++;
         total_cnt++;
         if (in_ready !== 1'b0) $display("FAIL sew8_busy_ready%0d got %b required 0", i, in_ready);
         else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++;
      if ({out_valid, in_ready} !== 2'b01) $display("FAIL sew8_done got v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
      else pass_cnt++;
   endtask

   task automatic test_sew16();
      logic [105:0] exp_b;
      exp_b = {1'b1, 64'h1234123412341234, 32'h100, 8'h3F, 1'b1};
      out_ready = 1'b1;
      send_cmd(2'b01, 64'h00000000FFFF1234, 16'd3, 32'h100);
      total_cnt++;
      if (beat_now() !== exp_b) $display("FAIL sew16_beat got %h required %h", beat_now(), exp_b);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL sew16_done got v=%b required 0", out_valid);
      else pass_cnt++;
   endtask

   // Start address 0xFFFFFFFF also exercises address wrap.
   task automatic test_sew32_stall();
      logic [105:0] exp_b [3];
      exp_b[0] = {1'b1, 64'hDEADBEEFDEADBEEF, 32'hFFFFFFFF, 8'hFF, 1'b0};
      exp_b[1] = {1'b1, 64'hDEADBEEFDEADBEEF, 32'h00000000, 8'hFF, 1'b0};
      exp_b[2] = {1'b1, 64'hDEADBEEFDEADBEEF, 32'h00000001, 8'h0F, 1'b1};
      out_ready = 1'b1;
      send_cmd(2'b10, 64'h12345678DEADBEEF, 16'd5, 32'hFFFFFFFF);
      for (int i = 0; i < 3; i++) begin
         total_cnt++;
         if (beat_now() !== exp_b[i]) $display("FAIL sew32_beat%0d got %h required %h", i, beat_now(), exp_b[i]);
         else pass_cnt++;
         if (i == 1) begin
            out_ready = 1'b0;
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               total_cnt++;
               if (beat_now() !== exp_b[1]) $display("FAIL sew32_hold%0d got %h required %h", c, beat_now(), exp_b[1]);
               else pass_cnt++;
            end
            out_ready = 1'b1;
         end
         @(negedge clk);
      end
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL sew32_done got v=%b required 0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_vl_zero();
      logic [105:0] exp_b;
      exp_b = {1'b1, 64'h3C3C3C3C3C3C3C3C, 32'h10, 8'h01, 1'b1};
      out_ready = 1'b1;
      send_cmd(2'b00, 64'h3C, 16'd0, 32'h80);
      for (int c = 0; c < 2; c++) begin
         total_cnt++;
         if ({out_valid, in_ready} !== 2'b01) $display("FAIL vl0_idle%0d got v=%b rdy=%b required v=0 rdy=1", c, out_valid, in_ready);
         else pass_cnt++;
         @(negedge clk);
      end
      send_cmd(2'b00, 64'h3C, 16'd1, 32'h10);
      total_cnt++;
      if (beat_now() !== exp_b) $display("FAIL vl1_beat got %h required %h", beat_now(), exp_b);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_sew64();
      out_ready = 1'b1;
      send_cmd(2'b11, 64'h0123456789ABCDEF, 16'd2, 32'h20);
`ifdef RVV_SPLAT_SEW64_EN
      begin
         logic [105:0] exp_b [2];
         exp_b[0] = {1'b1, 64'h0123456789ABCDEF, 32'h20, 8'hFF, 1'b0};
         exp_b[1] = {1'b1, 64'h0123456789ABCDEF, 32'h21, 8'hFF, 1'b1};
         for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if (beat_now() !== exp_b[i]) $display("FAIL sew64_beat%0d got %h required %h", i, beat_now(), exp_b[i]);
            else pass_cnt++;
            @(negedge clk);
         end
         total_cnt++;
         if (out_valid !== 1'b0) $display("FAIL sew64_done got v=%b required 0", out_valid);
         else pass_cnt++;
      end
`else
      total_cnt++;
      if ({out_err, out_valid} !== 2'b10) $display("FAIL sew64_err got err=%b v=%b required err=1 v=0", out_err, out_valid);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({out_err, out_valid} !== 2'b00) $display("FAIL sew64_err_end got err=%b v=%b required err=0 v=0", out_err, out_valid);
      else pass_cnt++;
`endif
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      send_cmd(2'b00, 64'h77, 16'd16, 32'h200);
      total_cnt++;
      if ({out_valid, out_addr, out_last} !== {1'b1, 32'h200, 1'b0})
         $display("FAIL rstmid_beat got v=%b addr=%h last=%b required v=1 addr=00000200 last=0", out_valid, out_addr, out_last);
      else pass_cnt++;
      #2 rst = 1'b0;
      #1;
      total_cnt++;
      if ({out_valid, in_ready, out_be} !== 10'b0) $display("FAIL rstmid_async got v=%b rdy=%b be=%h required 0", out_valid, in_ready, out_be);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total_cnt++;
         if ({out_valid, in_ready} !== 2'b01) $display("FAIL rstmid_after%0d got v=%b rdy=%b required v=0 rdy=1", c, out_valid, in_ready);
         else pass_cnt++;
      end
   endtask

   // Two commands issued as fast as the handshake allows.
   task automatic test_back_to_back();
      logic [105:0] exp_b [2];
      exp_b[0] = {1'b1, 64'h5555555555555555, 32'h300, 8'h7F, 1'b1};
      exp_b[1] = {1'b1, 64'hBEEFBEEFBEEFBEEF, 32'h400, 8'h03, 1'b1};
      out_ready = 1'b1;
      send_cmd(2'b00, 64'h55, 16'd7, 32'h300);
      total_cnt++;
      if (beat_now() !== exp_b[0]) $display("FAIL b2b_beat0 got %h required %h", beat_now(), exp_b[0]);
      else pass_cnt++;
      @(negedge clk);
      send_cmd(2'b01, 64'hBEEF, 16'd1, 32'h400);
      total_cnt++;
      if (beat_now() !== exp_b[1]) $display("FAIL b2b_beat1 got %h required %h", beat_now(), exp_b[1]);
      else pass_cnt++;
      @(negedge clk);
   endtask

   initial begin
      in_valid  = 1'b0;
      in_scalar = '0;
      in_sew    = '0;
      in_vl     = '0;
      in_addr   = '0;
      out_ready = 1'b0;
      test_reset();
      test_sew8();
      test_sew16();
      test_sew32_stall();
      test_vl_zero();
      test_sew64();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
